// File: rtl/operand_fetch_if.sv
// Operand-fetch bundle: decode handshake, register-file ports, writeback, execute handshake.
// Pure wiring, no latency of its own.
// Backpressure travels on in_ready/out_ready; the master modport drives the decode/execute side.
interface operand_fetch_if #(
  parameter int CTRL_W = 16
);
  // decode side
  logic              in_valid;
  logic              in_ready;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [4:0]        in_rd;
  logic              in_rd_we;
  logic [CTRL_W-1:0] in_ctrl;
  // register file
  logic [4:0]        rf_read_addr1;
  logic [4:0]        rf_read_addr2;
  logic [31:0]       rf_read_data1;
  logic [31:0]       rf_read_data2;
  // writeback
  logic              wb_valid;
  logic [4:0]        wb_addr;
  logic [31:0]       wb_data;
  // execute side
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_op1;
  logic [31:0]       out_op2;
  logic [4:0]        out_rd;
  logic              out_rd_we;
  logic [CTRL_W-1:0] out_ctrl;
  // control / status
  logic              flush;
  logic [15:0]       stall_count;

  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_ctrl,
    output rf_read_data1, rf_read_data2,
    output wb_valid, wb_addr, wb_data,
    output out_ready, flush,
    input  in_ready, rf_read_addr1, rf_read_addr2,
    input  out_valid, out_op1, out_op2, out_rd, out_rd_we, out_ctrl,
    input  stall_count
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_rd_we, in_ctrl,
    input  rf_read_data1, rf_read_data2,
    input  wb_valid, wb_addr, wb_data,
    input  out_ready, flush,
    output in_ready, rf_read_addr1, rf_read_addr2,
    output out_valid, out_op1, out_op2, out_rd, out_rd_we, out_ctrl,
    output stall_count
  );
endinterface

// File: rtl/operand_fetch.sv
// Operand fetch: reads sources, forwards writeback, tracks pending rd, blocks on RAW/WAW.
// Latency: 1 cycle from accept to out_valid.
// Backpressure: holds the output register while out_ready is low; in_ready drops on hazard/flush/full.
module operand_fetch #(
  parameter int CTRL_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  operand_fetch_if.slave   bus
);

  localparam logic [4:0] ZERO_REG = 5'd31;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       pending_q,   pending_d;
  logic [31:0]       op1_q,       op1_d;
  logic [31:0]       op2_q,       op2_d;
  logic [4:0]        rd_q,        rd_d;
  logic              rd_we_q,     rd_we_d;
  logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
  logic [15:0]       stall_q,     stall_d;

  logic        fwd1, fwd2;
  logic        raw1, raw2, waw;
  logic        hazard;
  logic        in_ready;
  logic        accept;
  logic [31:0] src1_val, src2_val;

  // Register-file addresses come straight from the decoded sources.
  assign bus.rf_read_addr1 = bus.in_rs1;
  assign bus.rf_read_addr2 = bus.in_rs2;

  // Forwarding, hazard detection and the input handshake.
  always_comb begin
    fwd1 = bus.wb_valid && (bus.wb_addr == bus.in_rs1) && (bus.in_rs1 != ZERO_REG);
    fwd2 = bus.wb_valid && (bus.wb_addr == bus.in_rs2) && (bus.in_rs2 != ZERO_REG);

    // A pending source that is being written back this cycle is satisfied by forwarding.
    raw1 = (bus.in_rs1 != ZERO_REG) && pending_q[bus.in_rs1] && !fwd1;
    raw2 = (bus.in_rs2 != ZERO_REG) && pending_q[bus.in_rs2] && !fwd2;
    waw  = bus.in_rd_we && (bus.in_rd != ZERO_REG) && pending_q[bus.in_rd] &&
           !(bus.wb_valid && (bus.wb_addr == bus.in_rd));

    hazard   = bus.in_valid && (raw1 || raw2 || waw);
    in_ready = rst_n && !bus.flush && !hazard && (!out_valid_q || bus.out_ready);
    accept   = bus.in_valid && in_ready;

    src1_val = 32'd0;
    if (bus.in_rs1 != ZERO_REG) src1_val = fwd1 ? bus.wb_data : bus.rf_read_data1;
    src2_val = 32'd0;
    if (bus.in_rs2 != ZERO_REG) src2_val = fwd2 ? bus.wb_data : bus.rf_read_data2;
  end

  // Next state: output register, pending scoreboard and stall counter.
  always_comb begin
    out_valid_d = out_valid_q;
    pending_d   = pending_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    rd_d        = rd_q;
    rd_we_d     = rd_we_q;
    ctrl_d      = ctrl_q;
    stall_d     = stall_q;

    // Clears first so that a same-cycle set from an accept wins.
    if (bus.wb_valid) pending_d[bus.wb_addr] = 1'b0;
    if (bus.flush && out_valid_q && rd_we_q) pending_d[rd_q] = 1'b0;

    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      op1_d       = src1_val;
      op2_d       = src2_val;
      rd_d        = bus.in_rd;
      rd_we_d     = bus.in_rd_we;
      ctrl_d      = bus.in_ctrl;
      if (bus.in_rd_we && (bus.in_rd != ZERO_REG)) pending_d[bus.in_rd] = 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // The zero register can never hold an outstanding result.
    pending_d[ZERO_REG] = 1'b0;

    if (hazard && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  // Control state: valid, scoreboard, stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      pending_q   <= 32'd0;
      stall_q     <= 16'd0;
    end else begin
      out_valid_q <= out_valid_d;
      pending_q   <= pending_d;
      stall_q     <= stall_d;
    end
  end

  // Output payload register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      rd_q    <= 5'd0;
      rd_we_q <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      rd_q    <= rd_d;
      rd_we_q <= rd_we_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_op1     = op1_q;
  assign bus.out_op2     = op2_q;
  assign bus.out_rd      = rd_q;
  assign bus.out_rd_we   = rd_we_q;
  assign bus.out_ctrl    = ctrl_q;
  assign bus.stall_count = stall_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small register-file model.
// Inputs change on the falling edge; registered outputs are sampled 1 time unit after the rising edge.
// The consumer is throttled only where a test asks for it.
module tb_operand_fetch;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  operand_fetch_if #(.CTRL_W(16)) bus ();

  operand_fetch #(.CTRL_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: reset contents 0x1000_00nn, x31 holds a nonzero value to expose the zero rule.
  logic [31:0] rf [32];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 31; i++) rf[i] <= 32'h1000_0000 + i;
      rf[31] <= 32'h1234_5678;
    end else if (bus.wb_valid) begin
      rf[bus.wb_addr] <= bus.wb_data;
    end
  end
  assign bus.rf_read_data1 = rf[bus.rf_read_addr1];
  assign bus.rf_read_data2 = rf[bus.rf_read_addr2];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_rs1   = 5'd0;
    bus.in_rs2   = 5'd0;
    bus.in_rd    = 5'd0;
    bus.in_rd_we = 1'b0;
    bus.in_ctrl  = 16'd0;
    bus.wb_valid = 1'b0;
    bus.wb_addr  = 5'd0;
    bus.wb_data  = 32'd0;
    bus.flush    = 1'b0;
  endtask

  task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                       input logic we, input logic [15:0] ctrl);
    bus.in_valid = 1'b1;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
    bus.in_rd_we = we;
    bus.in_ctrl  = ctrl;
  endtask

  task automatic wb(input logic [4:0] addr, input logic [31:0] data);
    bus.wb_valid = 1'b1;
    bus.wb_addr  = addr;
    bus.wb_data  = data;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_in();
    bus.out_ready = 1'b1;
    rst_n = 1'b0;

    // Reset state
    #3;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_stall", 32'(bus.stall_count), 32'd0);
    check("rst_op1", bus.out_op1, 32'd0);
    check("rst_pending", dut.pending_q, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // RAW stall on x3, released by a same-cycle writeback with forwarding
    issue(5'd0, 5'd1, 5'd3, 1'b1, 16'hA5A5);
    #1 check("t1_ready", 32'(bus.in_ready), 32'd1);
    check("t1_addr1", 32'(bus.rf_read_addr1), 32'd0);
    tick();
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_op1", bus.out_op1, 32'h1000_0000);
    check("t1_op2", bus.out_op2, 32'h1000_0001);
    check("t1_rd", 32'(bus.out_rd), 32'd3);
    check("t1_ctrl", 32'(bus.out_ctrl), 32'h0000_A5A5);
    check("t1_pend", dut.pending_q, 32'h0000_0008);
    @(negedge clk);
    issue(5'd3, 5'd0, 5'd4, 1'b1, 16'h0001);
    #1 check("t1_raw_ready", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_stall_cnt", 32'(bus.stall_count), 32'(i + 1));
      check("t1_stall_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    check("t1_drained", 32'(bus.out_valid), 32'd0);
    wb(5'd3, 32'hDEAD_BEEF);
    #1 check("t1_wb_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("t1_fwd_op1", bus.out_op1, 32'hDEAD_BEEF);
    check("t1_fwd_valid", 32'(bus.out_valid), 32'd1);
    check("t1_stall_hold", 32'(bus.stall_count), 32'd3);
    check("t1_pend2", dut.pending_q, 32'h0000_0010);
    @(negedge clk);
    idle_in();
    wb(5'd4, 32'h0000_0044);
    tick();
    check("t1_pend_clr", dut.pending_q, 32'd0);
    check("t1_valid_clr", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    idle_in();

    // Register 31 reads as zero and never becomes pending
    issue(5'd1, 5'd31, 5'd31, 1'b1, 16'h0031);
    tick();
    check("t2_op2_zero", bus.out_op2, 32'd0);
    check("t2_op1", bus.out_op1, 32'h1000_0001);
    check("t2_pend", dut.pending_q, 32'd0);
    check("t2_rd", 32'(bus.out_rd), 32'd31);

    // Backpressure holds outputs, then back-to-back accepts
    @(negedge clk);
    bus.out_ready = 1'b0;
    issue(5'd2, 5'd5, 5'd6, 1'b0, 16'h1111);
    #1 check("t3_bp_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("t3_hold_valid", 32'(bus.out_valid), 32'd1);
    check("t3_hold_op2", bus.out_op2, 32'd0);
    check("t3_hold_ctrl", 32'(bus.out_ctrl), 32'h0000_0031);
    check("t3_no_stall", 32'(bus.stall_count), 32'd3);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1 check("t3_ready_rel", 32'(bus.in_ready), 32'd1);
    tick();
    check("t3_acc_op1", bus.out_op1, 32'h1000_0002);
    check("t3_acc_op2", bus.out_op2, 32'h1000_0005);
    check("t3_acc_ctrl", 32'(bus.out_ctrl), 32'h0000_1111);
    @(negedge clk);
    issue(5'd8, 5'd9, 5'd10, 1'b0, 16'h2222);
    #1 check("t3_b2b_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("t3_b2b_valid", 32'(bus.out_valid), 32'd1);
    check("t3_b2b_op1", bus.out_op1, 32'h1000_0008);
    check("t3_b2b_ctrl", 32'(bus.out_ctrl), 32'h0000_2222);
    @(negedge clk);
    idle_in();

    // Accept setting x5 wins over a same-cycle writeback clearing x5
    issue(5'd0, 5'd0, 5'd5, 1'b1, 16'h0005);
    tick();
    check("t4_pend_set", dut.pending_q, 32'h0000_0020);
    @(negedge clk);
    issue(5'd0, 5'd0, 5'd5, 1'b1, 16'h0055);
    wb(5'd5, 32'h0000_0055);
    #1 check("t4_waw_clear_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("t4_set_wins", dut.pending_q, 32'h0000_0020);
    check("t4_ctrl", 32'(bus.out_ctrl), 32'h0000_0055);
    @(negedge clk);
    idle_in();
    wb(5'd5, 32'h0000_0056);
    tick();
    check("t4_pend_clr", dut.pending_q, 32'd0);
    @(negedge clk);
    idle_in();

    // Flush drops the held x7 producer and its pending bit
    bus.out_ready = 1'b0;
    issue(5'd0, 5'd0, 5'd7, 1'b1, 16'h0007);
    tick();
    check("t5_valid", 32'(bus.out_valid), 32'd1);
    check("t5_pend", dut.pending_q, 32'h0000_0080);
    @(negedge clk);
    idle_in();
    bus.flush = 1'b1;
    #1 check("t5_flush_ready", 32'(bus.in_ready), 32'd0);
    tick();
    check("t5_flush_valid", 32'(bus.out_valid), 32'd0);
    check("t5_flush_pend", dut.pending_q, 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    issue(5'd7, 5'd0, 5'd8, 1'b0, 16'h0008);
    #1 check("t5_no_stall_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("t5_op1", bus.out_op1, 32'h1000_0007);
    check("t5_stall_cnt", 32'(bus.stall_count), 32'd3);
    @(negedge clk);
    idle_in();

    // Reset asserted mid-stall clears everything at once
    issue(5'd0, 5'd0, 5'd9, 1'b1, 16'h0009);
    tick();
    @(negedge clk);
    issue(5'd9, 5'd0, 5'd9, 1'b1, 16'h0099);
    tick();
    check("t6_stall_cnt", 32'(bus.stall_count), 32'd4);
    check("t6_pend", dut.pending_q, 32'h0000_0200);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_op1", bus.out_op1, 32'd0);
    check("t6_rst_rd", 32'(bus.out_rd), 32'd0);
    check("t6_rst_ctrl", 32'(bus.out_ctrl), 32'd0);
    check("t6_rst_pend", dut.pending_q, 32'd0);
    check("t6_rst_stall", 32'(bus.stall_count), 32'd0);
    check("t6_rst_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("t6_rel_ready", 32'(bus.in_ready), 32'd1);
    tick();
    check("t6_rel_valid", 32'(bus.out_valid), 32'd1);
    check("t6_rel_op1", bus.out_op1, 32'h1000_0009);
    check("t6_rel_pend", dut.pending_q, 32'h0000_0200);
    @(negedge clk);
    idle_in();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter CTRL_W, default 16, width of the opaque decoded-control bundle passed through unchanged.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports in_valid input 1, in_ready output 1  decode-side handshake.
REQ-005 SHALL have ports in_rs1, in_rs2, in_rd  input  5 each  source and destination register numbers.
REQ-006 SHALL have ports in_rd_we input 1 (instruction writes rd) and in_ctrl input CTRL_W.
REQ-007 SHALL have ports rf_read_addr1, rf_read_addr2  output  5 each  register-file read addresses.
REQ-008 SHALL have ports rf_read_data1, rf_read_data2  input  32 each  combinational register-file read data.
REQ-009 SHALL have ports wb_valid input 1, wb_addr input 5, wb_data input 32  writeback, written into the register file at the same posedge.
REQ-010 SHALL have ports out_valid output 1, out_ready input 1  execute-side handshake.
REQ-011 SHALL have ports out_op1, out_op2 output 32, out_rd output 5, out_rd_we output 1, out_ctrl output CTRL_W.
REQ-012 SHALL have ports flush input 1 (synchronous kill) and stall_count output 16.

Function
REQ-013 SHALL drive rf_read_addr1/2 combinationally from in_rs1/in_rs2.
REQ-014 SHALL treat register 31 as hardwired zero: source 31 reads 0, is never pending, and is never forwarded; rd 31 never sets pending.
REQ-015 SHALL keep a 32-bit pending vector, one bit per register with an issued but not yet written-back result.
REQ-016 SHALL forward wb_data for a source when wb_valid and wb_addr equals that source (not 31); otherwise use rf_read_data.
REQ-017 SHALL raise a RAW hazard when a source (not 31) is pending and is not being written back in the same cycle.
REQ-018 SHALL raise a WAW hazard when in_rd_we, in_rd is not 31, pending[in_rd] is set, and wb is not clearing it in the same cycle.
REQ-019 SHALL drive in_ready = !flush && !hazard && (!out_valid || out_ready), and hazard is evaluated only when in_valid.
REQ-020 SHALL accept on in_valid && in_ready and load the output register at that posedge, giving 1-cycle latency.
REQ-021 SHALL, on accept, set pending[in_rd] if in_rd_we and in_rd is not 31.
REQ-022 SHALL clear pending[wb_addr] on wb_valid; if the same register is set by an accept in the same cycle, set wins.
REQ-023 SHALL clear out_valid on out_valid && out_ready with no accept, and hold all outputs while out_valid && !out_ready.
REQ-024 SHALL, on flush, clear out_valid and clear pending[out_rd] when the held entry has out_rd_we, while accepting nothing that cycle.
REQ-025 SHALL increment stall_count each cycle in which in_valid && hazard, saturating at 0xFFFF.

Reset
REQ-026 SHALL, while rst_n is low, asynchronously clear out_valid, the pending vector, out_op1, out_op2, out_rd, out_rd_we, out_ctrl, and stall_count.
REQ-027 SHALL hold in_ready low while rst_n is low, and shall drop any in-flight entry when reset is asserted mid-operation.

Verification
REQ-028 Issue x3 <- (rd=3, we=1), then rs1=3 with no writeback -> in_ready=0, stall_count increments each cycle; wb_valid, wb_addr=3, wb_data=0xDEADBEEF -> accept that cycle, out_op1=0xDEADBEEF next cycle.
REQ-029 Source rs2=31 with rf_read_data2=0x12345678 -> out_op2=0; rd=31, we=1 -> pending stays 0.
REQ-030 out_ready=0 with out_valid=1 -> outputs stable and in_ready=0; out_ready=1 plus a new in_valid -> back-to-back accept with no bubble.
REQ-031 Pending x5 and wb to x5 in the same cycle as an accept with rd=5 -> pending[5]=1 afterwards.
REQ-032 Held entry with rd=7, we=1, flush=1 -> out_valid=0 and pending[7]=0 next cycle; a later rs1=7 issues without stall.
REQ-033 rst_n low mid-stall with pending nonzero -> all outputs 0 and pending 0 immediately; first instruction after release accepted.
